// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the sequential shifter: shift-mode codes and FSM state encoding.
package seq_shift_unit_pkg;

  localparam logic [1:0] SHIFT_LSR = 2'b00;
  localparam logic [1:0] SHIFT_ASR = 2'b01;
  localparam logic [1:0] SHIFT_LSL = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational single-position shift step for one of four modes, returning the bit shifted out.
module shift_step
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch inferred.
    data_o  = {1'b0, data_i[WIDTH-1:1]};
    carry_o = data_i[0];
    case (mode_i)
      SHIFT_ASR: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      SHIFT_LSL: begin
        data_o  = {data_i[WIDTH-2:0], 1'b0};
        carry_o = data_i[WIDTH-1];
      end
      SHIFT_ROR: data_o = {data_i[0], data_i[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-mode sequential shifter: one bit position per clock, valid/ready on both sides.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMTW-1:0]  count_q, count_d;

  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i  (data_q),
    .mode_i  (mode_q),
    .data_o  (step_data),
    .carry_o (step_carry)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          carry_d = 1'b0;
          mode_d  = in_mode;
          count_d = in_amt;
          state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        count_d = count_q - AMTW'(1);
        // The step taken with one position remaining is the last one.
        if (count_q == AMTW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= SHIFT_LSR;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=8) against an arithmetic reference model.
module tb_seq_shift_unit;
  import seq_shift_unit_pkg::*;

  localparam int W    = 8;
  localparam int AMTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [AMTW-1:0] in_amt;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_carry;
  logic            busy;

  int errors = 0;
  int checks = 0;

  seq_shift_unit #(.WIDTH(W), .AMTW(AMTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: whole-operand shifts by the full amount, carry = last bit to leave.
  function automatic void model(input logic [W-1:0] d, input int amt, input logic [1:0] mode,
                                output logic [W-1:0] r, output logic c);
    logic [2*W-1:0] dbl;
    int k;
    r = d;
    c = 1'b0;
    case (mode)
      SHIFT_LSR: begin
        r = (amt >= W) ? '0 : d >> amt;
        if (amt > 0) c = (amt <= W) ? d[amt-1] : 1'b0;
      end
      SHIFT_ASR: begin
        r = $signed(d) >>> amt;
        if (amt > 0) c = (amt <= W) ? d[amt-1] : d[W-1];
      end
      SHIFT_LSL: begin
        r = (amt >= W) ? '0 : d << amt;
        if (amt > 0) c = (amt <= W) ? d[W-amt] : 1'b0;
      end
      default: begin
        k   = amt % W;
        dbl = {d, d} >> k;
        r   = dbl[W-1:0];
        if (amt > 0) c = r[W-1];
      end
    endcase
  endfunction

  // Drives one request; returns result and accept->out_valid latency (-1 on timeout).
  task automatic run_op(input logic [W-1:0] d, input int amt, input logic [1:0] mode,
                        input bit drain, output logic [W-1:0] res, output logic car,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt[AMTW-1:0];
    in_mode  = mode;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    res = out_data;
    car = out_carry;
    if (drain && out_valid) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_data !== 8'h00 || out_carry !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_during: data=%h carry=%b valid=%b busy=%b ready=%b, want 00 0 0 0 1",
               out_data, out_carry, out_valid, busy, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: valid=%b busy=%b ready=%b, want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] d_t[7] = '{8'hB4, 8'h90, 8'h81, 8'h01, 8'hFF, 8'h80, 8'h5A};
    int           a_t[7] = '{3, 2, 1, 9, 8, 15, 0};
    logic [1:0]   m_t[7] = '{SHIFT_LSR, SHIFT_ASR, SHIFT_LSL, SHIFT_ROR, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR};
    logic [W-1:0] r_t[7] = '{8'h16, 8'hE4, 8'h02, 8'h80, 8'h00, 8'hFF, 8'h5A};
    logic         c_t[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] res;
    logic         car;
    int           lat;
    for (int i = 0; i < 7; i++) begin
      run_op(d_t[i], a_t[i], m_t[i], 1'b1, res, car, lat);
      checks++;
      if (res !== r_t[i] || car !== c_t[i] || lat != a_t[i] + 1) begin
        errors++;
        $display("FAIL directed_%0d: data=%h carry=%b lat=%0d, want %h %b %0d",
                 i, res, car, lat, r_t[i], c_t[i], a_t[i] + 1);
      end
    end
  endtask

  task automatic test_amt_zero();
    logic [W-1:0] res;
    logic         car;
    int           lat;
    for (int m = 0; m < 4; m++) begin
      run_op(8'h5A, 0, m[1:0], 1'b1, res, car, lat);
      checks++;
      if (res !== 8'h5A || car !== 1'b0 || lat != 1) begin
        errors++;
        $display("FAIL amt_zero_mode%0d: data=%h carry=%b lat=%0d, want 5a 0 1", m, res, car, lat);
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] res;
    logic         car;
    int           lat;
    run_op(8'hB4, 3, SHIFT_LSR, 1'b0, res, car, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h3C;
      in_amt   = 4'd1;
      in_mode  = SHIFT_LSL;
      @(negedge clk);
      checks++;
      if (out_data !== 8'h16 || out_carry !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: data=%h carry=%b valid=%b ready=%b busy=%b, want 16 1 1 0 1",
                 i, out_data, out_carry, out_valid, in_ready, busy);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] res, exp_r;
    logic         car, exp_c;
    int           lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hC3;
    in_amt   = 4'd12;
    in_mode  = SHIFT_LSR;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_data !== 8'h00 || out_carry !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: data=%h carry=%b valid=%b busy=%b ready=%b, want 00 0 0 0 1",
               out_data, out_carry, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model(8'hA7, 5, SHIFT_ASR, exp_r, exp_c);
    run_op(8'hA7, 5, SHIFT_ASR, 1'b1, res, car, lat);
    checks++;
    if (res !== exp_r || car !== exp_c || lat != 6) begin
      errors++;
      $display("FAIL after_reset_op: data=%h carry=%b lat=%0d, want %h %b 6",
               res, car, lat, exp_r, exp_c);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, res, exp_r;
    logic [1:0]   m;
    logic         car, exp_c;
    int           a, lat;
    for (int i = 0; i < 40; i++) begin
      d = W'($urandom);
      a = int'($urandom_range(0, 15));
      m = 2'($urandom);
      model(d, a, m, exp_r, exp_c);
      run_op(d, a, m, 1'b1, res, car, lat);
      checks++;
      if (res !== exp_r || car !== exp_c || lat != a + 1) begin
        errors++;
        $display("FAIL random_%0d (d=%h amt=%0d mode=%0d): data=%h carry=%b lat=%0d, want %h %b %0d",
                 i, d, a, m, res, car, lat, exp_r, exp_c, a + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res, exp_r;
    logic         car, exp_c;
    int           lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model(8'hE1 + W'(i), W + i, i[1:0], exp_r, exp_c);
      run_op(8'hE1 + W'(i), W + i, i[1:0], 1'b0, res, car, lat);
      checks++;
      if (res !== exp_r || car !== exp_c || lat != W + i + 1) begin
        errors++;
        $display("FAIL b2b_%0d: data=%h carry=%b lat=%0d, want %h %b %0d",
                 i, res, car, lat, exp_r, exp_c, W + i + 1);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = SHIFT_LSR;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_amt_zero();
    test_hold();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
